// File: rtl/pow_exp_pkg.sv
// Shared constants, Q16.16 types and ROM/helper functions for the pow_exp unit.
// Build option: define POW_ROUND_EN for round-to-nearest-even mantissa output.
package pow_exp_pkg;

    localparam int INPUTOUTBIT = 32;

    typedef logic signed [31:0] q16_t;

    localparam q16_t Q_ONE          = 32'sh0001_0000;
    localparam q16_t LN2            = 32'sh0000_B172;
    localparam q16_t INV_LN2        = 32'sh0001_7154;
    localparam q16_t CORDIC_INVGAIN = 32'sh0001_351F;

    // Exponent limits are compared against the full-width product so large b cannot wrap.
    localparam logic signed [63:0] TMAX = 64'sh0000_0000_0059_0000;
    localparam logic signed [63:0] TMIN = 64'shFFFF_FFFF_FFA8_0000;

    localparam logic [15:0] BF16_ONE  = 16'h3F80;
    localparam logic [15:0] BF16_INF  = 16'h7F80;
    localparam logic [15:0] BF16_ZERO = 16'h0000;

    localparam logic MODE_VEC = 1'b0;
    localparam logic MODE_ROT = 1'b1;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_VALIDATE = 4'd1;
    localparam logic [3:0] ST_PREP_LN  = 4'd2;
    localparam logic [3:0] ST_CALC_LN  = 4'd3;
    localparam logic [3:0] ST_MUL      = 4'd4;
    localparam logic [3:0] ST_REDUCE   = 4'd5;
    localparam logic [3:0] ST_PREP_EXP = 4'd6;
    localparam logic [3:0] ST_CALC_EXP = 4'd7;
    localparam logic [3:0] ST_CONVERT  = 4'd8;
    localparam logic [3:0] ST_DONE     = 4'd9;

    function automatic q16_t atanh_rom(input logic [4:0] i);
        q16_t v;
        case (i)
            5'd1:    v = 32'sh0000_8C9F;
            5'd2:    v = 32'sh0000_4163;
            5'd3:    v = 32'sh0000_202B;
            5'd4:    v = 32'sh0000_1005;
            5'd5:    v = 32'sh0000_0801;
            5'd6:    v = 32'sh0000_0400;
            5'd7:    v = 32'sh0000_0200;
            5'd8:    v = 32'sh0000_0100;
            5'd9:    v = 32'sh0000_0080;
            5'd10:   v = 32'sh0000_0040;
            5'd11:   v = 32'sh0000_0020;
            5'd12:   v = 32'sh0000_0010;
            5'd13:   v = 32'sh0000_0008;
            5'd14:   v = 32'sh0000_0004;
            5'd15:   v = 32'sh0000_0002;
            5'd16:   v = 32'sh0000_0001;
            default: v = 32'sh0000_0000;
        endcase
        return v;
    endfunction

    function automatic logic [5:0] clz32(input logic [31:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (found) begin
                n = n;
            end else if (v[i]) begin
                found = 1'b1;
            end else begin
                n = n + 6'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/pow_exp_cordic.sv
// One combinational hyperbolic CORDIC micro-rotation in Q16.16 (vectoring or rotation mode).
module cordic_hyp_step
    import pow_exp_pkg::*;
(
    input  logic        mode,
    input  logic [4:0]  i,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] z,
    output logic [31:0] x_n,
    output logic [31:0] y_n,
    output logic [31:0] z_n
);

    q16_t xs_s;
    q16_t ys_s;
    q16_t at_s;
    logic add_s;

    // Vectoring drives y toward zero, rotation drives z toward zero; both share one add/sub datapath.
    always_comb begin
        xs_s = $signed(x) >>> i;
        ys_s = $signed(y) >>> i;
        at_s = atanh_rom(i);
        if (mode == MODE_ROT) begin
            add_s = ~z[31];
        end else begin
            add_s = y[31];
        end
        if (add_s) begin
            x_n = x + ys_s;
            y_n = y + xs_s;
            z_n = z - at_s;
        end else begin
            x_n = x - ys_s;
            y_n = y - xs_s;
            z_n = z + at_s;
        end
    end

endmodule

// File: rtl/pow_exp.sv
// a^b (a>0 integer, b signed integer) to BF16 via CORDIC ln, range reduction and CORDIC exp.
// Build option: POW_ROUND_EN selects round-to-nearest-even instead of mantissa truncation.
module pow_exp
    import pow_exp_pkg::*;
#(
    parameter int ITERATIONS = 16
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [INPUTOUTBIT-1:0] a,
    input  logic [INPUTOUTBIT-1:0] b,
    output logic [15:0]            result,
    output logic                   error,
    output logic                   done
);

    logic [3:0]  state_r;
    q16_t        a_r, b_r, x_r, y_r, z_r, t_r, k_r;
    logic [5:0]  s_r;
    logic [4:0]  it_r;
    logic        rep_r;
    logic [15:0] result_r;
    logic        error_r;
    logic        done_r;

    logic        mode_s, repeat_s, last_s;
    logic [31:0] x_n_s, y_n_s, z_n_s;
    logic [5:0]  s_s;
    logic [31:0] norm_s;
    q16_t        m_s, lna_s, k_s, r0_s, r_s, kf_s, e_s, e_n_s, k_adj_s, exp_s;
    logic signed [63:0] prod_s, kp_s;
    logic [7:0]  mant_s;
    logic [15:0] conv_res_s;
    logic        conv_err_s;
`ifdef POW_ROUND_EN
    logic        round_up_s;
`endif
    logic        unused_ok_s;

    assign result = result_r;
    assign error  = error_r;
    assign done   = done_r;

    cordic_hyp_step u_step (
        .mode (mode_s),
        .i    (it_r),
        .x    (x_r),
        .y    (y_r),
        .z    (z_r),
        .x_n  (x_n_s),
        .y_n  (y_n_s),
        .z_n  (z_n_s)
    );

    // Iteration sequencing: i=4 and i=13 run twice so the hyperbolic CORDIC converges.
    always_comb begin
        if (state_r == ST_CALC_EXP) begin
            mode_s = MODE_ROT;
        end else begin
            mode_s = MODE_VEC;
        end
        repeat_s = ((it_r == 5'd4) || (it_r == 5'd13)) && !rep_r;
        last_s   = (it_r == 5'(ITERATIONS));
    end

    // Normalisation, ln scaling, product and range reduction arithmetic.
    always_comb begin
        s_s    = clz32(a_r);
        norm_s = a_r << s_s;
        m_s    = {16'h0000, norm_s[31:16]};
        lna_s  = (z_r <<< 1) + ($signed({26'd0, 6'd32 - s_r}) * LN2);
        // b is an integer, so the low word of this product is the Q16.16 t directly.
        prod_s = {{32{lna_s[31]}}, lna_s} * {{32{b_r[31]}}, b_r};
        kp_s   = {{32{t_r[31]}}, t_r} * {32'd0, INV_LN2};
        k_s    = kp_s[63:32];
        r0_s   = t_r - (k_s * LN2);
        if (r0_s < 32'sd0) begin
            r_s  = r0_s + LN2;
            kf_s = k_s - 32'sd1;
        end else if (r0_s >= LN2) begin
            r_s  = r0_s - LN2;
            kf_s = k_s + 32'sd1;
        end else begin
            r_s  = r0_s;
            kf_s = k_s;
        end
    end

    // BF16 packing; e is renormalised in either direction to absorb CORDIC error near 1.0 and 2.0.
    always_comb begin
        e_s     = x_r + y_r;
        e_n_s   = e_s;
        k_adj_s = k_r;
        if (e_s[31:17] != 15'd0) begin
            e_n_s   = e_s >>> 1;
            k_adj_s = k_r + 32'sd1;
        end else if (e_s[16] == 1'b0) begin
            e_n_s   = e_s <<< 1;
            k_adj_s = k_r - 32'sd1;
        end else begin
            e_n_s   = e_s;
        end
        exp_s = 32'sd127 + k_adj_s;
`ifdef POW_ROUND_EN
        round_up_s = e_n_s[8] & ((|e_n_s[7:0]) | e_n_s[9]);
        mant_s     = {1'b0, e_n_s[15:9]} + {7'd0, round_up_s};
        if (mant_s[7]) begin
            exp_s = exp_s + 32'sd1;
        end else begin
            exp_s = exp_s;
        end
`else
        mant_s = {1'b0, e_n_s[15:9]};
`endif
        if (exp_s > 32'sd254) begin
            conv_err_s = 1'b1;
            conv_res_s = BF16_INF;
        end else if (exp_s < 32'sd1) begin
            conv_err_s = 1'b0;
            conv_res_s = BF16_ZERO;
        end else begin
            conv_err_s = 1'b0;
            conv_res_s = {1'b0, exp_s[7:0], mant_s[6:0]};
        end
    end

    assign unused_ok_s = ^{norm_s[15:0], kp_s[31:0], e_n_s[31:16], e_n_s[8:0], mant_s[7]};

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            a_r      <= 32'sd0;
            b_r      <= 32'sd0;
            x_r      <= 32'sd0;
            y_r      <= 32'sd0;
            z_r      <= 32'sd0;
            t_r      <= 32'sd0;
            k_r      <= 32'sd0;
            s_r      <= 6'd0;
            it_r     <= 5'd0;
            rep_r    <= 1'b0;
            result_r <= 16'h0000;
            error_r  <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r  <= 1'b0;
                    error_r <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        state_r <= ST_VALIDATE;
                    end
                end
                ST_VALIDATE: begin
                    if (a_r <= 32'sd0) begin
                        error_r <= 1'b1;
                        state_r <= ST_DONE;
                    end else if ((b_r == 32'sd0) || (a_r == 32'sd1)) begin
                        result_r <= BF16_ONE;
                        state_r  <= ST_DONE;
                    end else begin
                        state_r <= ST_PREP_LN;
                    end
                end
                ST_PREP_LN: begin
                    s_r     <= s_s;
                    x_r     <= m_s + Q_ONE;
                    y_r     <= m_s - Q_ONE;
                    z_r     <= 32'sd0;
                    it_r    <= 5'd1;
                    rep_r   <= 1'b0;
                    state_r <= ST_CALC_LN;
                end
                ST_CALC_LN, ST_CALC_EXP: begin
                    x_r <= x_n_s;
                    y_r <= y_n_s;
                    z_r <= z_n_s;
                    if (repeat_s) begin
                        rep_r <= 1'b1;
                    end else begin
                        rep_r <= 1'b0;
                        it_r  <= it_r + 5'd1;
                    end
                    if (last_s) begin
                        state_r <= (state_r == ST_CALC_LN) ? ST_MUL : ST_CONVERT;
                    end
                end
                ST_MUL: begin
                    t_r <= prod_s[31:0];
                    if (prod_s > TMAX) begin
                        error_r  <= 1'b1;
                        result_r <= BF16_INF;
                        state_r  <= ST_DONE;
                    end else if (prod_s < TMIN) begin
                        result_r <= BF16_ZERO;
                        state_r  <= ST_DONE;
                    end else begin
                        state_r <= ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    t_r     <= r_s;
                    k_r     <= kf_s;
                    state_r <= ST_PREP_EXP;
                end
                ST_PREP_EXP: begin
                    x_r     <= CORDIC_INVGAIN;
                    y_r     <= 32'sd0;
                    z_r     <= t_r;
                    it_r    <= 5'd1;
                    rep_r   <= 1'b0;
                    state_r <= ST_CALC_EXP;
                end
                ST_CONVERT: begin
                    result_r <= conv_res_s;
                    error_r  <= conv_err_s;
                    state_r  <= ST_DONE;
                end
                ST_DONE: begin
                    done_r <= 1'b1;
                    if (!start) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pow_exp.sv
// Directed self-checking bench for pow_exp with hand-computed BF16 expectations.
module tb_pow_exp;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] result;
    logic        error;
    logic        done;

    int n_asserts;
    int n_fail;
    int lat;
    logic [15:0] prev_res;

    pow_exp dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .result (result),
        .error  (error),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert ((obs === exp_v) || (obs === exp_v + 32'd1) || (obs === exp_v - 32'd1)) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h +/-1", tag, obs, exp_v);
        end
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, output int cyc);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        cyc   = 0;
        while ((done !== 1'b1) && (cyc < 200)) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic finish_op();
        int cnt;
        @(negedge clk);
        start = 1'b0;
        cnt   = 0;
        while ((done !== 1'b0) && (cnt < 10)) begin
            @(negedge clk);
            cnt++;
        end
        chk("done_drop", {31'd0, done}, 32'd0);
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_done",   {31'd0, done},  32'd0);
        chk("rst_error",  {31'd0, error}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'h0000_0000);
        rst = 1'b0;

        // 2^10 plus latency bound and start-held behaviour
        run_op(32'd2, 32'd10, lat);
        chk("latency_le_46", {31'd0, (lat - 1) <= 46}, 32'd1);
        chk("p2_10_err", {31'd0, error}, 32'd0);
        chk_near("p2_10_res", {16'd0, result}, 32'h0000_4480);
        prev_res = result;
        repeat (5) @(negedge clk);
        chk("hold_done", {31'd0, done}, 32'd1);
        chk("hold_res", {16'd0, result}, {16'd0, prev_res});
        finish_op();
        repeat (3) @(negedge clk);
        chk("idle_done_low", {31'd0, done}, 32'd0);

        run_op(32'd0, 32'd5, lat);
        chk("a0_err", {31'd0, error}, 32'd1);
        chk("a0_res_kept", {16'd0, result}, {16'd0, prev_res});
        finish_op();

        run_op(32'hFFFF_FFFB, 32'd3, lat);
        chk("aneg_err", {31'd0, error}, 32'd1);
        chk("aneg_res_kept", {16'd0, result}, {16'd0, prev_res});
        finish_op();

        run_op(32'd7, 32'd0, lat);
        chk("b0_err", {31'd0, error}, 32'd0);
        chk("b0_res", {16'd0, result}, 32'h0000_3F80);
        finish_op();

        run_op(32'd1, 32'hFFFF_FFF7, lat);
        chk("a1_err", {31'd0, error}, 32'd0);
        chk("a1_res", {16'd0, result}, 32'h0000_3F80);
        finish_op();

        run_op(32'd3, 32'd4, lat);
        chk("p3_4_err", {31'd0, error}, 32'd0);
        chk_near("p3_4_res", {16'd0, result}, 32'h0000_42A2);
        finish_op();

        run_op(32'd2, 32'hFFFF_FFFD, lat);
        chk("p2_m3_err", {31'd0, error}, 32'd0);
        chk_near("p2_m3_res", {16'd0, result}, 32'h0000_3E00);
        finish_op();

        run_op(32'd2, 32'd200, lat);
        chk("ovf_err", {31'd0, error}, 32'd1);
        chk("ovf_res", {16'd0, result}, 32'h0000_7F80);
        finish_op();

        run_op(32'd2, 32'hFFFF_FF38, lat);
        chk("unf_err", {31'd0, error}, 32'd0);
        chk("unf_res", {16'd0, result}, 32'h0000_0000);
        finish_op();

        run_op(32'd3, 32'd5, lat);
        chk("p3_5_err", {31'd0, error}, 32'd0);
`ifdef POW_ROUND_EN
        chk("p3_5_round", {16'd0, result}, 32'h0000_4373);
`else
        chk_near("p3_5_res", {16'd0, result}, 32'h0000_4373);
`endif
        finish_op();

        // reset while the exp CORDIC is running
        @(negedge clk);
        a     = 32'd3;
        b     = 32'd4;
        start = 1'b1;
        repeat (30) @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("midrst_done",   {31'd0, done},  32'd0);
        chk("midrst_error",  {31'd0, error}, 32'd0);
        chk("midrst_result", {16'd0, result}, 32'h0000_0000);
        rst = 1'b0;

        run_op(32'd3, 32'd4, lat);
        chk("post_rst_err", {31'd0, error}, 32'd0);
        chk_near("post_rst_res", {16'd0, result}, 32'h0000_42A2);
        finish_op();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
